// File: rtl/instr_exec.sv
// instr_exec: fetch/execute sequencer for the 19-bit program ROM.
// Drives the ROM address from an internal PC, latches the returned word,
// decodes it and runs one 8-bit ALU operation per instruction against an
// 8x8 register file. Each instruction takes two cycles (FETCH then EXEC).
module instr_exec #(
    parameter int PROG_LEN = 9,
    parameter int AW       = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    output logic [AW-1:0] rom_addr,
    input  logic [18:0]   rom_data,
    output logic          busy,
    output logic          halt,
    output logic [7:0]    result,
    output logic          result_valid,
    output logic          flag_z,
    output logic          flag_c,
    input  logic [2:0]    dbg_sel,
    output logic [7:0]    dbg_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_LDI  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Address of the final program word; reaching it ends the program.
    localparam logic [AW-1:0] LAST_PC = AW'(PROG_LEN - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [18:0]   ir_q, ir_d;
    logic [7:0]    regFile_q [8];
    logic [7:0]    result_q, result_d;
    logic          resultValid_q, resultValid_d;
    logic          flagZ_q, flagZ_d;
    logic          flagC_q, flagC_d;
    logic          regWe;

    // Instruction fields of the latched word.
    logic [2:0] rd;
    logic [2:0] opcode;
    logic [2:0] rs;
    logic       bsel;
    logic [7:0] imm;
    logic       unusedReserved;

    assign rd             = ir_q[18:16];
    assign opcode         = ir_q[15:13];
    assign rs             = ir_q[12:10];
    assign unusedReserved = ir_q[9];
    assign bsel           = ir_q[8];
    assign imm            = ir_q[7:0];

    // Operands come from the registers as they stand before the EXEC edge,
    // so rd==rs reads the old value and writes the new one.
    logic [7:0] opA;
    logic [7:0] opB;

    assign opA = regFile_q[rs];
    assign opB = bsel ? imm : regFile_q[rd];

    logic [8:0] sum9;
    logic [7:0] aluValue;
    logic       aluCarry;

    // ALU: produces the writeback value and the 9th sum bit for ADD/SUB.
    always_comb begin
        sum9     = '0;
        aluValue = '0;
        aluCarry = 1'b0;
        case (opcode)
            OP_ADD: begin
                sum9     = {1'b0, opA} + {1'b0, opB};
                aluValue = sum9[7:0];
                aluCarry = sum9[8];
            end
            OP_SUB: begin
                sum9     = {1'b0, opA} + {1'b0, ~opB} + 9'd1;
                aluValue = sum9[7:0];
                aluCarry = sum9[8];
            end
            OP_AND:  aluValue = opA & opB;
            OP_OR:   aluValue = opA | opB;
            OP_XOR:  aluValue = opA ^ opB;
            OP_NOT:  aluValue = ~opA;
            OP_LDI:  aluValue = imm;
            default: aluValue = '0;
        endcase
    end

    // Sequencer: next state, PC, IR and the writeback side effects of EXEC.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        result_d      = result_q;
        resultValid_d = 1'b0;
        flagZ_d       = flagZ_q;
        flagC_d       = flagC_q;
        regWe         = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ir_d    = rom_data;
                state_d = EXEC;
            end
            EXEC: begin
                if (opcode != OP_HALT) begin
                    regWe         = 1'b1;
                    result_d      = aluValue;
                    resultValid_d = 1'b1;
                    flagZ_d       = (aluValue == 8'd0);
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        flagC_d = aluCarry;
                    end
                end
                if (pc_q == LAST_PC || opcode == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    pc_d    = pc_q + AW'(1);
                    state_d = FETCH;
                end
            end
            HALT: begin
                if (run) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            result_q      <= '0;
            resultValid_q <= 1'b0;
            flagZ_q       <= 1'b0;
            flagC_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            result_q      <= result_d;
            resultValid_q <= resultValid_d;
            flagZ_q       <= flagZ_d;
            flagC_q       <= flagC_d;
        end
    end

    // Register file: cleared by reset, written by EXEC for non-HALT opcodes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                regFile_q[i] <= '0;
            end
        end else if (regWe) begin
            regFile_q[rd] <= aluValue;
        end
    end

    assign rom_addr     = pc_q;
    assign busy         = (state_q == FETCH) || (state_q == EXEC);
    assign halt         = (state_q == HALT);
    assign result       = result_q;
    assign result_valid = resultValid_q;
    assign flag_z       = flagZ_q;
    assign flag_c       = flagC_q;
    assign dbg_data     = regFile_q[dbg_sel];

endmodule

// File: tb/tb_instr_exec.sv
// tb_instr_exec: drives instr_exec from a bench-side ROM array and checks
// every result_valid pulse against a queue of expected writebacks, plus
// hand-written checks of reset, halt, restart and mid-instruction reset.
module tb_instr_exec;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       c;
    } exp_t;

    typedef struct {
        logic [18:0] word;
        logic [7:0]  expRes;
        logic        expZ;
        logic        expC;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        run;
    logic [5:0]  romAddr;
    logic [18:0] romData;
    logic        busy;
    logic        halt;
    logic [7:0]  result;
    logic        resultValid;
    logic        flagZ;
    logic        flagC;
    logic [2:0]  dbgSel;
    logic [7:0]  dbgData;

    logic [18:0] rom [64];
    exp_t        expQ [$];
    vec_t        progTable [9];
    int          checks = 0;
    int          errors = 0;
    int          cycles;

    instr_exec #(.PROG_LEN(9), .AW(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .rom_addr    (romAddr),
        .rom_data    (romData),
        .busy        (busy),
        .halt        (halt),
        .result      (result),
        .result_valid(resultValid),
        .flag_z      (flagZ),
        .flag_c      (flagC),
        .dbg_sel     (dbgSel),
        .dbg_data    (dbgData)
    );

    assign romData = rom[romAddr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [18:0] enc(input logic [2:0] rd, input logic [2:0] op,
                                        input logic [2:0] rs, input logic bsel,
                                        input logic [7:0] imm);
        return {rd, op, rs, 1'b0, bsel, imm};
    endfunction

    function automatic vec_t mkVec(input logic [18:0] word, input logic [7:0] res,
                                   input logic z, input logic c);
        vec_t v;
        v.word   = word;
        v.expRes = res;
        v.expZ   = z;
        v.expC   = c;
        return v;
    endfunction

    function automatic exp_t mkExp(input logic [7:0] res, input logic z, input logic c);
        exp_t e;
        e.res = res;
        e.z   = z;
        e.c   = c;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic resetV, input logic runV);
        reset = resetV;
        run   = runV;
        tick();
    endtask

    task automatic checkReg(input int idx, input logic [7:0] expected);
        dbgSel = 3'(idx);
        #1;
        checkOutput($sformatf("reg%0d", idx), {24'd0, dbgData}, {24'd0, expected});
    endtask

    task automatic clearRom();
        for (int i = 0; i < 64; i++) rom[i] = enc(3'd0, 3'b111, 3'd0, 1'b0, 8'h00);
    endtask

    // Waits for HALT with a cycle budget, then lets the final pulse drain.
    task automatic waitHalt(input int budget, output int count);
        count = 0;
        while (!halt && count < budget) begin
            tick();
            count++;
        end
        checkOutput("haltReached", {31'd0, halt}, 32'd1);
        tick();
        checkOutput("queueDrained", expQ.size(), 0);
    endtask

    // Scoreboard monitor: every pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (resultValid === 1'b1) begin
            checkOutput("pulseExpected", {31'd0, expQ.size() > 0}, 32'd1);
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("result", {24'd0, result}, {24'd0, e.res});
                checkOutput("flagZ", {31'd0, flagZ}, {31'd0, e.z});
                checkOutput("flagC", {31'd0, flagC}, {31'd0, e.c});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Table program: runs to PROG_LEN-1 without a HALT opcode.
        progTable[0] = mkVec(enc(3'd3, 3'b110, 3'd0, 1'b1, 8'h02), 8'h02, 1'b0, 1'b0);
        progTable[1] = mkVec(enc(3'd3, 3'b001, 3'd3, 1'b1, 8'h05), 8'hFD, 1'b0, 1'b0);
        progTable[2] = mkVec(enc(3'd3, 3'b010, 3'd3, 1'b1, 8'h0F), 8'h0D, 1'b0, 1'b0);
        progTable[3] = mkVec(enc(3'd4, 3'b110, 3'd0, 1'b1, 8'hA5), 8'hA5, 1'b0, 1'b0);
        progTable[4] = mkVec(enc(3'd4, 3'b101, 3'd4, 1'b0, 8'h00) | 19'h00200, 8'h5A, 1'b0, 1'b0);
        progTable[5] = mkVec(enc(3'd4, 3'b100, 3'd4, 1'b1, 8'h5A), 8'h00, 1'b1, 1'b0);
        progTable[6] = mkVec(enc(3'd5, 3'b001, 3'd3, 1'b0, 8'h00), 8'h0D, 1'b0, 1'b1);
        progTable[7] = mkVec(enc(3'd0, 3'b110, 3'd0, 1'b1, 8'hFF), 8'hFF, 1'b0, 1'b1);
        progTable[8] = mkVec(enc(3'd0, 3'b000, 3'd0, 1'b1, 8'h01), 8'h00, 1'b1, 1'b1);

        reset  = 1'b0;
        run    = 1'b0;
        dbgSel = 3'd0;
        clearRom();

        // Reset state.
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstHalt", {31'd0, halt}, 32'd0);
        checkOutput("rstRomAddr", {26'd0, romAddr}, 32'd0);
        checkOutput("rstResult", {24'd0, result}, 32'd0);
        checkOutput("rstValid", {31'd0, resultValid}, 32'd0);
        checkOutput("rstFlags", {30'd0, flagZ, flagC}, 32'd0);
        for (int i = 0; i < 8; i++) checkReg(i, 8'h00);

        // Program A: LDI r1,5; LDI r2,3; ADD r2,r1; HALT.
        rom[0] = enc(3'd1, 3'b110, 3'd0, 1'b1, 8'h05);
        rom[1] = enc(3'd2, 3'b110, 3'd0, 1'b1, 8'h03);
        rom[2] = enc(3'd2, 3'b000, 3'd1, 1'b0, 8'h00);
        rom[3] = enc(3'd0, 3'b111, 3'd0, 1'b0, 8'h00);
        expQ.push_back(mkExp(8'h05, 1'b0, 1'b0));
        expQ.push_back(mkExp(8'h03, 1'b0, 1'b0));
        expQ.push_back(mkExp(8'h08, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("aBusyAfterRun", {31'd0, busy}, 32'd1);
        run = 1'b0;
        waitHalt(40, cycles);
        checkOutput("aHaltCycles", cycles, 8);
        checkOutput("aRomAddr", {26'd0, romAddr}, 32'd3);
        checkOutput("aBusyInHalt", {31'd0, busy}, 32'd0);
        checkOutput("aFlags", {30'd0, flagZ, flagC}, 32'd0);
        checkReg(2, 8'h08);
        checkReg(1, 8'h05);

        // Program B (table): ends at PROG_LEN-1 without a HALT opcode.
        applyStimulus(1'b0, 1'b0);
        clearRom();
        for (int i = 0; i < 9; i++) begin
            rom[i] = progTable[i].word;
            expQ.push_back(mkExp(progTable[i].expRes, progTable[i].expZ, progTable[i].expC));
        end
        applyStimulus(1'b1, 1'b1);
        run = 1'b0;
        waitHalt(60, cycles);
        checkOutput("bRomAddr", {26'd0, romAddr}, 32'd8);
        checkOutput("bResult", {24'd0, result}, 32'h00);
        checkOutput("bFlags", {30'd0, flagZ, flagC}, 32'd3);
        checkReg(3, 8'h0D);
        checkReg(4, 8'h00);
        checkReg(5, 8'h0D);
        checkReg(0, 8'h00);

        // Program C: restart from HALT with run held through FETCH/EXEC.
        clearRom();
        rom[0] = enc(3'd6, 3'b011, 3'd3, 1'b1, 8'h30);
        rom[1] = enc(3'd6, 3'b000, 3'd4, 1'b0, 8'h00);
        expQ.push_back(mkExp(8'h3D, 1'b0, 1'b1));
        expQ.push_back(mkExp(8'h3D, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b1);
        checkOutput("cBusyRestart", {31'd0, busy}, 32'd1);
        checkOutput("cHaltCleared", {31'd0, halt}, 32'd0);
        checkOutput("cRomAddr0", {26'd0, romAddr}, 32'd0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("cRunIgnored", {26'd0, romAddr}, 32'd1);
        applyStimulus(1'b1, 1'b1);
        run = 1'b0;
        waitHalt(40, cycles);
        checkOutput("cRomAddr", {26'd0, romAddr}, 32'd2);
        checkReg(6, 8'h3D);
        checkReg(3, 8'h0D);
        checkReg(5, 8'h0D);

        // Program D: reset asserted during EXEC of an ADD.
        applyStimulus(1'b0, 1'b0);
        clearRom();
        rom[0] = enc(3'd7, 3'b000, 3'd7, 1'b1, 8'h11);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("dInExec", {30'd0, busy, halt}, 32'd2);
        applyStimulus(1'b0, 1'b0);
        checkOutput("dBusy", {31'd0, busy}, 32'd0);
        checkOutput("dHalt", {31'd0, halt}, 32'd0);
        checkOutput("dResult", {24'd0, result}, 32'd0);
        checkOutput("dValid", {31'd0, resultValid}, 32'd0);
        checkOutput("dFlags", {30'd0, flagZ, flagC}, 32'd0);
        checkReg(7, 8'h00);
        applyStimulus(1'b1, 1'b0);
        checkOutput("dIdleHolds", {31'd0, busy}, 32'd0);
        expQ.push_back(mkExp(8'h11, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b1);
        checkOutput("dRestartBusy", {31'd0, busy}, 32'd1);
        checkOutput("dRestartAddr", {26'd0, romAddr}, 32'd0);
        run = 1'b0;
        waitHalt(40, cycles);
        checkOutput("dRomAddr", {26'd0, romAddr}, 32'd1);
        checkReg(7, 8'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
